blimp_v6_test_harness: RTL and testbench

Verification harness block for the BlimpV6 out-of-order core. It provides two request/response memory ports, one for instructions and one for data, backed by a single shared word memory. Each port has programmable request and response pacing. A commit-trace checker compares every retired instruction against a preloaded expectation queue. The core connects to the proc-facing ports, and the bench drives the load, expectation and status ports.

---
 rtl/blimp_v6_test_harness_if.sv | 30 +++
 rtl/blimp_v6_test_harness.sv | 206 ++++++++++++++++++++
 tb/tb_blimp_v6_test_harness.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/blimp_v6_test_harness_if.sv
// Request/response memory port between the BlimpV6 core (master) and the
// verification harness (slave).
interface blimp_v6_test_harness_if #(
    parameter int p_opaq_bits = 8
);
    logic                   req_val;
    logic                   req_rdy;
    logic [p_opaq_bits-1:0] req_opaque;
    logic                   req_op;
    logic [31:0]            req_addr;
    logic [31:0]            req_data;
    logic [3:0]             req_strb;

    logic                   resp_val;
    logic                   resp_rdy;
    logic [p_opaq_bits-1:0] resp_opaque;
    logic                   resp_op;
    logic [31:0]            resp_addr;
    logic [31:0]            resp_data;

    modport master (
        output req_val, req_opaque, req_op, req_addr, req_data, req_strb, resp_rdy,
        input  req_rdy, resp_val, resp_opaque, resp_op, resp_addr, resp_data
    );

    modport slave (
        input  req_val, req_opaque, req_op, req_addr, req_data, req_strb, resp_rdy,
        output req_rdy, resp_val, resp_opaque, resp_op, resp_addr, resp_data
    );
endinterface

// File: rtl/blimp_v6_test_harness.sv
// BlimpV6 verification harness: paced imem/dmem ports over one shared word
// memory, plus a commit-trace checker against a preloaded expectation queue.
module blimp_v6_test_harness #(
    parameter int p_opaq_bits           = 8,
    parameter int p_seq_num_bits        = 5,
    parameter int p_num_phys_regs       = 36,
    parameter int p_mem_send_intv_delay = 1,
    parameter int p_mem_recv_intv_delay = 1,
    parameter int p_mem_words           = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    blimp_v6_test_harness_if.slave imem,
    blimp_v6_test_harness_if.slave dmem,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        trace_val,
    input  logic [31:0] trace_pc,
    input  logic [4:0]  trace_waddr,
    input  logic [31:0] trace_wdata,
    input  logic        trace_wen,
    input  logic        exp_push,
    input  logic [31:0] exp_pc,
    input  logic [4:0]  exp_waddr,
    input  logic [31:0] exp_wdata,
    input  logic        exp_wen,
    output logic        done,
    output logic        err,
    output logic [15:0] err_cnt
);
    localparam int AW = $clog2(p_mem_words);
    localparam int SW = $clog2(p_mem_send_intv_delay + 1);
    localparam int RW = $clog2(p_mem_recv_intv_delay + 1);
    localparam logic [SW-1:0] SEND_LD = SW'(p_mem_send_intv_delay - 1);
    localparam logic [RW-1:0] RECV_LD = RW'(p_mem_recv_intv_delay - 1);

    generate
        if (p_seq_num_bits < 1 || p_num_phys_regs < 33 || p_mem_send_intv_delay < 1 ||
            p_mem_recv_intv_delay < 1 || (p_mem_words & (p_mem_words - 1)) != 0) begin : g_bad_cfg
            $error("blimp_v6_test_harness: illegal parameter combination");
        end
    endgenerate

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [31:0] mem [p_mem_words];

    // Port 0 is imem, port 1 is dmem; dmem writes land after imem writes.
    logic [1:0]             req_val, req_op, req_rdy, resp_rdy, acc_p0, vld_p1, deq_p1;
    logic [p_opaq_bits-1:0] req_opq [2];
    logic [31:0]            req_addr [2];
    logic [31:0]            req_data [2];
    logic [3:0]             req_strb [2];
    logic [AW-1:0]          widx [2];
    logic [31:0]            rd_word_p0 [2];

    logic [p_opaq_bits-1:0] q_opq  [2][4];
    logic                   q_op   [2][4];
    logic [31:0]            q_addr [2][4];
    logic [31:0]            q_data [2][4];
    logic [1:0]             wr_ptr [2];
    logic [1:0]             rd_ptr [2];
    logic [2:0]             q_cnt  [2];
    logic [SW-1:0]          send_cnt [2];
    logic [RW-1:0]          recv_cnt [2];

    logic [AW-1:0] ld_idx;
    logic          unused_ld_addr;
    assign ld_idx         = ld_addr[AW+1:2];
    assign unused_ld_addr = ^{ld_addr[31:AW+2], ld_addr[1:0]};

    // Stage p0: request acceptance and word capture
    always_comb begin
        req_val     = {dmem.req_val, imem.req_val};
        req_op      = {dmem.req_op, imem.req_op};
        resp_rdy    = {dmem.resp_rdy, imem.resp_rdy};
        req_opq[0]  = imem.req_opaque;
        req_opq[1]  = dmem.req_opaque;
        req_addr[0] = imem.req_addr;
        req_addr[1] = dmem.req_addr;
        req_data[0] = imem.req_data;
        req_data[1] = dmem.req_data;
        req_strb[0] = imem.req_strb;
        req_strb[1] = dmem.req_strb;
        for (int p = 0; p < 2; p++) begin
            // Gating with rst_n keeps rdy low while reset is held.
            req_rdy[p]    = rst_n && (q_cnt[p] != 3'd4) && (send_cnt[p] == '0);
            acc_p0[p]     = req_val[p] && req_rdy[p];
            widx[p]       = req_addr[p][AW+1:2];
            rd_word_p0[p] = mem[widx[p]];
            vld_p1[p]     = (q_cnt[p] != 3'd0) && (recv_cnt[p] == '0);
            deq_p1[p]     = vld_p1[p] && resp_rdy[p];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (acc_p0[p] && req_op[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_strb[p][b]) mem[widx[p]][8*b +: 8] <= req_data[p][8*b +: 8];
                end
            end
        end
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    // Stage p1: response FIFOs and pacing counters
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (acc_p0[p]) begin
                q_opq[p][wr_ptr[p]]  <= req_opq[p];
                q_op[p][wr_ptr[p]]   <= req_op[p];
                q_addr[p][wr_ptr[p]] <= req_addr[p];
                q_data[p][wr_ptr[p]] <= req_op[p] ? 32'd0 : rd_word_p0[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p]   <= 2'd0;
                rd_ptr[p]   <= 2'd0;
                q_cnt[p]    <= 3'd0;
                send_cnt[p] <= '0;
                recv_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= wr_ptr[p] + 2'(acc_p0[p]);
                rd_ptr[p] <= rd_ptr[p] + 2'(deq_p1[p]);
                q_cnt[p]  <= q_cnt[p] + 3'(acc_p0[p]) - 3'(deq_p1[p]);
                if (acc_p0[p])               send_cnt[p] <= SEND_LD;
                else if (send_cnt[p] != '0)  send_cnt[p] <= send_cnt[p] - SW'(1);
                if (deq_p1[p])               recv_cnt[p] <= RECV_LD;
                else if (recv_cnt[p] != '0)  recv_cnt[p] <= recv_cnt[p] - RW'(1);
            end
        end
    end

    assign imem.req_rdy     = req_rdy[0];
    assign imem.resp_val    = vld_p1[0];
    assign imem.resp_opaque = q_opq[0][rd_ptr[0]];
    assign imem.resp_op     = q_op[0][rd_ptr[0]];
    assign imem.resp_addr   = q_addr[0][rd_ptr[0]];
    assign imem.resp_data   = q_data[0][rd_ptr[0]];
    assign dmem.req_rdy     = req_rdy[1];
    assign dmem.resp_val    = vld_p1[1];
    assign dmem.resp_opaque = q_opq[1][rd_ptr[1]];
    assign dmem.resp_op     = q_op[1][rd_ptr[1]];
    assign dmem.resp_addr   = q_addr[1][rd_ptr[1]];
    assign dmem.resp_data   = q_data[1][rd_ptr[1]];

    // Commit-trace checker
    logic [31:0] e_pc    [32];
    logic [4:0]  e_waddr [32];
    logic [31:0] e_wdata [32];
    logic        e_wen   [32];
    logic [4:0]  e_wr, e_rd;
    logic [5:0]  e_cnt;
    logic        e_pop, e_push, miss_trace, miss_push;
    logic [1:0]  n_miss;

    always_comb begin
        e_pop      = trace_val && (e_cnt != 6'd0);
        e_push     = exp_push && ((e_cnt != 6'd32) || e_pop);
        miss_push  = exp_push && !e_push;
        miss_trace = trace_val && ((e_cnt == 6'd0) ||
                     (trace_pc != e_pc[e_rd]) || (trace_wen != e_wen[e_rd]) ||
                     (e_wen[e_rd] && (e_waddr[e_rd] != 5'd0) &&
                      ((trace_waddr != e_waddr[e_rd]) || (trace_wdata != e_wdata[e_rd]))));
        n_miss     = 2'(miss_trace) + 2'(miss_push);
    end

    always_ff @(posedge clk) begin
        if (e_push) begin
            e_pc[e_wr]    <= exp_pc;
            e_waddr[e_wr] <= exp_waddr;
            e_wdata[e_wr] <= exp_wdata;
            e_wen[e_wr]   <= exp_wen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_wr    <= 5'd0;
            e_rd    <= 5'd0;
            e_cnt   <= 6'd0;
            err     <= 1'b0;
            err_cnt <= 16'd0;
        end else begin
            e_wr    <= e_wr + 5'(e_push);
            e_rd    <= e_rd + 5'(e_pop);
            e_cnt   <= e_cnt + 6'(e_push) - 6'(e_pop);
            err     <= err | (n_miss != 2'd0);
            err_cnt <= sat_add(err_cnt, n_miss);
        end
    end

    assign done = (e_cnt == 6'd0);
endmodule

// File: tb/tb_blimp_v6_test_harness.sv
// Directed bench for blimp_v6_test_harness: memory ports, pacing, backpressure,
// trace checking and mid-stream reset.
module tb_blimp_v6_test_harness;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;
    logic        trace_val, trace_wen, exp_push, exp_wen;
    logic [31:0] trace_pc, trace_wdata, exp_pc, exp_wdata;
    logic [4:0]  trace_waddr, exp_waddr;
    logic        done, err, done3, err3;
    logic [15:0] err_cnt, err_cnt3;

    blimp_v6_test_harness_if #(.p_opaq_bits(8)) im ();
    blimp_v6_test_harness_if #(.p_opaq_bits(8)) dm ();
    blimp_v6_test_harness_if #(.p_opaq_bits(8)) im3 ();
    blimp_v6_test_harness_if #(.p_opaq_bits(8)) dm3 ();

    blimp_v6_test_harness dut (
        .clk(clk), .rst_n(rst_n), .imem(im), .dmem(dm),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .trace_val(trace_val), .trace_pc(trace_pc), .trace_waddr(trace_waddr),
        .trace_wdata(trace_wdata), .trace_wen(trace_wen),
        .exp_push(exp_push), .exp_pc(exp_pc), .exp_waddr(exp_waddr),
        .exp_wdata(exp_wdata), .exp_wen(exp_wen),
        .done(done), .err(err), .err_cnt(err_cnt)
    );

    blimp_v6_test_harness #(.p_mem_send_intv_delay(3), .p_mem_recv_intv_delay(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .imem(im3), .dmem(dm3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .trace_val(trace_val), .trace_pc(trace_pc), .trace_waddr(trace_waddr),
        .trace_wdata(trace_wdata), .trace_wen(trace_wen),
        .exp_push(exp_push), .exp_pc(exp_pc), .exp_waddr(exp_waddr),
        .exp_wdata(exp_wdata), .exp_wen(exp_wen),
        .done(done3), .err(err3), .err_cnt(err_cnt3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int acc_cyc [4];
    int resp_cyc [4];
    logic [7:0] resp_opq [4];
    int na, nr;

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        trace_val = 1'b0; trace_pc = '0; trace_waddr = '0; trace_wdata = '0; trace_wen = 1'b0;
        exp_push = 1'b0; exp_pc = '0; exp_waddr = '0; exp_wdata = '0; exp_wen = 1'b0;
        im.req_val = 0; im.req_opaque = 0; im.req_op = 0; im.req_addr = 0; im.req_data = 0; im.req_strb = 0; im.resp_rdy = 1;
        dm.req_val = 0; dm.req_opaque = 0; dm.req_op = 0; dm.req_addr = 0; dm.req_data = 0; dm.req_strb = 0; dm.resp_rdy = 1;
        im3.req_val = 0; im3.req_opaque = 0; im3.req_op = 0; im3.req_addr = 0; im3.req_data = 0; im3.req_strb = 0; im3.resp_rdy = 1;
        dm3.req_val = 0; dm3.req_opaque = 0; dm3.req_op = 0; dm3.req_addr = 0; dm3.req_data = 0; dm3.req_strb = 0; dm3.resp_rdy = 1;

        // Reset values
        tick(); tick();
        chk("rst_i_rdy", 32'(im.req_rdy), 0);
        chk("rst_d_rdy", 32'(dm.req_rdy), 0);
        chk("rst_i_val", 32'(im.resp_val), 0);
        chk("rst_d_val", 32'(dm.resp_val), 0);
        chk("rst_done", 32'(done), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_i_rdy", 32'(im.req_rdy), 1);
        chk("post_rst_d_rdy", 32'(dm.req_rdy), 1);

        // Pacing on the delay-3 instance: accepts at 0,3,6,9 and responses at 1,4,7,10
        na = 0; nr = 0;
        for (int c = 0; c < 16; c++) begin
            im3.req_val = (na < 4);
            im3.req_opaque = 8'(na);
            im3.req_addr = 32'(na * 4);
            #1;
            if (im3.req_val && im3.req_rdy) begin acc_cyc[na] = c; na++; end
            if (im3.resp_val) begin
                if (nr < 4) begin resp_cyc[nr] = c; resp_opq[nr] = im3.resp_opaque; end
                nr++;
            end
            tick();
        end
        im3.req_val = 0;
        chk("pace_acc_n", 32'(na), 4);
        chk("pace_resp_n", 32'(nr), 4);
        for (int i = 0; i < 4; i++) begin
            chk("pace_acc_cyc", 32'(acc_cyc[i]), 32'(3 * i));
            chk("pace_resp_cyc", 32'(resp_cyc[i]), 32'(3 * i + 1));
            chk("pace_resp_opq", 32'(resp_opq[i]), 32'(i));
        end

        // Preload
        ld_en = 1; ld_addr = 32'h100; ld_data = 32'hDEADBEEF; tick();
        ld_addr = 32'h200; ld_data = 32'h0; tick();
        ld_en = 0;

        // Basic read
        dm.req_val = 1; dm.req_op = 0; dm.req_addr = 32'h100; dm.req_opaque = 8'h5A;
        #1 chk("rd_rdy", 32'(dm.req_rdy), 1);
        tick();
        dm.req_val = 0;
        #1;
        chk("rd_val", 32'(dm.resp_val), 1);
        chk("rd_data", dm.resp_data, 32'hDEADBEEF);
        chk("rd_opq", 32'(dm.resp_opaque), 32'h5A);
        chk("rd_addr", dm.resp_addr, 32'h100);
        chk("rd_op", 32'(dm.resp_op), 0);
        tick();
        chk("rd_drained", 32'(dm.resp_val), 0);

        // Byte-enable write then cross-port read
        dm.req_val = 1; dm.req_op = 1; dm.req_addr = 32'h200; dm.req_data = 32'h11223344;
        dm.req_strb = 4'b0101; dm.req_opaque = 8'h01;
        tick();
        dm.req_val = 0;
        im.req_val = 1; im.req_op = 0; im.req_addr = 32'h200; im.req_opaque = 8'h07;
        #1;
        chk("wr_resp_val", 32'(dm.resp_val), 1);
        chk("wr_resp_data", dm.resp_data, 0);
        chk("wr_resp_op", 32'(dm.resp_op), 1);
        tick();
        im.req_val = 0;
        #1;
        chk("be_rd_val", 32'(im.resp_val), 1);
        chk("be_rd_data", im.resp_data, 32'h00220044);
        tick();

        // Same-cycle write ordering and address wrap
        im.req_val = 1; im.req_op = 1; im.req_addr = 32'h300; im.req_data = 32'hAAAAAAAA; im.req_strb = 4'hF;
        dm.req_val = 1; dm.req_op = 1; dm.req_addr = 32'h300; dm.req_data = 32'hBBBBBBBB; dm.req_strb = 4'hF;
        tick();
        im.req_val = 0;
        dm.req_addr = 32'h304; dm.req_data = 32'hDDDDDDDD;
        ld_en = 1; ld_addr = 32'h304; ld_data = 32'hCCCCCCCC;
        #1 chk("sustain_rdy", 32'(dm.req_rdy), 1);
        tick();
        ld_en = 0;
        im.req_val = 1; im.req_op = 0; im.req_addr = 32'h300; im.req_opaque = 8'h0A;
        dm.req_op = 0; dm.req_addr = 32'h304; dm.req_opaque = 8'h0B;
        tick();
        im.req_addr = 32'h4100; im.req_opaque = 8'h0C;
        dm.req_val = 0;
        #1;
        chk("order_dmem_last", im.resp_data, 32'hBBBBBBBB);
        chk("order_ld_last", dm.resp_data, 32'hCCCCCCCC);
        chk("order_opq", 32'(dm.resp_opaque), 32'h0B);
        tick();
        im.req_val = 0;
        #1;
        chk("wrap_data", im.resp_data, 32'hDEADBEEF);
        chk("wrap_addr", im.resp_addr, 32'h4100);
        tick();

        // Backpressure: four fill the FIFO, the fifth stalls
        dm.resp_rdy = 0;
        dm.req_val = 1; dm.req_op = 0;
        for (int i = 0; i < 4; i++) begin
            dm.req_opaque = 8'(i + 1);
            dm.req_addr = (i == 0) ? 32'h100 : (i == 1) ? 32'h200 : (i == 2) ? 32'h300 : 32'h304;
            #1 chk("bp_fill_rdy", 32'(dm.req_rdy), 1);
            tick();
        end
        dm.req_opaque = 8'h05; dm.req_addr = 32'h4100;
        #1 chk("bp_full_rdy", 32'(dm.req_rdy), 0);
        tick();
        chk("bp_stall_rdy", 32'(dm.req_rdy), 0);
        chk("bp_head_opq", 32'(dm.resp_opaque), 1);
        dm.resp_rdy = 1;
        #1 chk("bp_same_cycle_rdy", 32'(dm.req_rdy), 0);
        chk("bp_r1_data", dm.resp_data, 32'hDEADBEEF);
        tick();
        chk("bp_freed_rdy", 32'(dm.req_rdy), 1);
        chk("bp_r2_opq", 32'(dm.resp_opaque), 2);
        chk("bp_r2_data", dm.resp_data, 32'h00220044);
        tick();
        dm.req_val = 0;
        #1;
        chk("bp_r3_opq", 32'(dm.resp_opaque), 3);
        chk("bp_r3_data", dm.resp_data, 32'hBBBBBBBB);
        tick();
        chk("bp_r4_opq", 32'(dm.resp_opaque), 4);
        chk("bp_r4_data", dm.resp_data, 32'hCCCCCCCC);
        tick();
        chk("bp_r5_opq", 32'(dm.resp_opaque), 5);
        chk("bp_r5_data", dm.resp_data, 32'hDEADBEEF);
        tick();
        chk("bp_empty", 32'(dm.resp_val), 0);

        // Trace match then mismatch
        exp_push = 1; exp_pc = 32'h0; exp_waddr = 5'd1; exp_wdata = 32'd5; exp_wen = 1; tick();
        exp_pc = 32'h4; exp_waddr = 5'd0; exp_wdata = 32'd0; exp_wen = 0; tick();
        exp_push = 0;
        #1 chk("tr_pending_done", 32'(done), 0);
        trace_val = 1; trace_pc = 32'h0; trace_waddr = 5'd1; trace_wdata = 32'd5; trace_wen = 1; tick();
        trace_pc = 32'h4; trace_waddr = 5'd3; trace_wdata = 32'd9; trace_wen = 0; tick();
        trace_val = 0;
        #1;
        chk("tr_match_done", 32'(done), 1);
        chk("tr_match_err", 32'(err), 0);
        chk("tr_match_cnt", 32'(err_cnt), 0);
        trace_val = 1; trace_pc = 32'h8; tick();
        trace_val = 0;
        #1;
        chk("tr_extra_err", 32'(err), 1);
        chk("tr_extra_cnt", 32'(err_cnt), 1);
        exp_push = 1; exp_pc = 32'h8; exp_waddr = 5'd2; exp_wdata = 32'd7; exp_wen = 1; tick();
        exp_push = 0;
        trace_val = 1; trace_pc = 32'h8; trace_waddr = 5'd2; trace_wdata = 32'd6; trace_wen = 1; tick();
        trace_val = 0;
        #1 chk("tr_wdata_cnt", 32'(err_cnt), 2);
        exp_push = 1; exp_pc = 32'hC; exp_waddr = 5'd0; exp_wdata = 32'd1; exp_wen = 1; tick();
        exp_push = 0;
        trace_val = 1; trace_pc = 32'hC; trace_waddr = 5'd0; trace_wdata = 32'd99; trace_wen = 1; tick();
        trace_val = 0;
        #1;
        chk("tr_x0_cnt", 32'(err_cnt), 2);
        chk("tr_x0_done", 32'(done), 1);
        exp_push = 1; exp_pc = 32'h40; exp_wen = 0;
        repeat (33) tick();
        exp_push = 0;
        #1;
        chk("tr_overflow_cnt", 32'(err_cnt), 3);
        chk("tr_overflow_done", 32'(done), 0);

        // Reset mid-stream
        dm.resp_rdy = 0;
        dm.req_val = 1; dm.req_op = 0; dm.req_addr = 32'h200; dm.req_opaque = 8'h21; tick();
        dm.req_addr = 32'h300; dm.req_opaque = 8'h22; tick();
        dm.req_val = 0;
        #1 chk("mid_pending_val", 32'(dm.resp_val), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_val", 32'(dm.resp_val), 0);
        chk("mid_rst_done", 32'(done), 1);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_cnt", 32'(err_cnt), 0);
        chk("mid_rst_rdy", 32'(dm.req_rdy), 0);
        tick(); tick();
        rst_n = 1;
        dm.resp_rdy = 1;
        dm.req_val = 1; dm.req_op = 0; dm.req_addr = 32'h200; dm.req_opaque = 8'h31;
        im.req_val = 1; im.req_op = 0; im.req_addr = 32'h300; im.req_opaque = 8'h32;
        #1 chk("mid_rel_rdy", 32'(dm.req_rdy), 1);
        tick();
        dm.req_val = 0; im.req_val = 0;
        #1;
        chk("mid_keep_val", 32'(dm.resp_val), 1);
        chk("mid_keep_opq", 32'(dm.resp_opaque), 32'h31);
        chk("mid_keep_d", dm.resp_data, 32'h00220044);
        chk("mid_keep_i", im.resp_data, 32'hBBBBBBBB);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
